i2c_arbiter: RTL and testbench

- Shares one i2c_fsm write engine between NUM_REQ independent requesters.
- Each requester presents an AXI-Stream-style valid/ready write request (7-bit slave address + data byte).
- The arbiter picks one request round-robin, latches it, pulses the engine's start, tracks the engine's ready through the transfer, then reports completion with the requester index.
- Sits directly in front of i2c_fsm inside the axis-i2c-master top.

---
 rtl/i2c_pkg.sv | 15 +
 rtl/i2c_rr_pick.sv | 34 +++
 rtl/i2c_arbiter.sv | 176 +++++++++++++++++
 tb/tb_i2c_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and default widths for the I2C master slice.
// Used by the write arbiter and its round-robin picker.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first set request
// at or after ptr, wrapping modulo N.
module i2c_rr_pick
  import i2c_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  // scan N positions starting at ptr, keep the first hit
  always_comb begin
    int j;
    any     = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin front end sharing one i2c write engine.
// Optional watchdog: define I2C_ARB_TIMEOUT_EN.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = I2C_ADDR_W,
  parameter int DATA_WIDTH     = I2C_DATA_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          arstn,
  input  logic [NUM_REQ-1:0]            s_valid,
  output logic [NUM_REQ-1:0]            s_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
  output logic                          m_start,
  output logic [ADDR_WIDTH-1:0]         m_addr,
  output logic [DATA_WIDTH-1:0]         m_data,
  input  logic                          m_ready,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NUM_REQ)-1:0]    done_id,
  output logic                          err
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 ||
      TIMEOUT_CYCLES < 2) begin : g_cfg_err
    $error("i2c_arbiter: bad parameters");
  end

  arb_state_t            state_q, state_d;
  logic [IW-1:0]         rr_q, rr_d;
  logic [IW-1:0]         gid_q, gid_d;
  logic [IW-1:0]         rr_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic [IW-1:0]         did_q, did_d;
  logic                  any;
  logic [NUM_REQ-1:0]    gnt;
  logic [IW-1:0]         gnt_idx;
  logic                  hs;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW =
    ($clog2(TIMEOUT_CYCLES) > 8) ?
    $clog2(TIMEOUT_CYCLES) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          to_hit;
  assign to_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign err    = err_q;
`else
  assign err = 1'b0;
`endif

  i2c_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req     (s_valid),
    .ptr     (rr_q),
    .any     (any),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // grant only while idle with the engine ready
  assign s_ready = (arstn && state_q == IDLE &&
                    m_ready && any) ? gnt : '0;
  assign hs      = |s_ready;
  assign rr_nxt  = (gid_q == IW'(NUM_REQ - 1)) ?
                   '0 : gid_q + IW'(1);

  assign m_start = (state_q == ISSUE);
  assign busy    = (state_q != IDLE);
  assign m_addr  = addr_q;
  assign m_data  = data_q;
  assign done    = done_q;
  assign done_id = did_q;

  // next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    did_d   = did_q;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d   = cnt_q + CW'(1);
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          addr_d  = s_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
          data_d  = s_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
          gid_d   = gnt_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT_BUSY: begin
        if (!m_ready) begin
          state_d = WAIT_DONE;
`ifdef I2C_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (to_hit) begin
          err_d   = 1'b1;
          rr_d    = rr_nxt;
          state_d = IDLE;
        end
`endif
      end
      WAIT_DONE: begin
        if (m_ready) begin
          done_d  = 1'b1;
          did_d   = gid_q;
          rr_d    = rr_nxt;
          state_d = IDLE;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (to_hit) begin
          err_d   = 1'b1;
          rr_d    = rr_nxt;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gid_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      did_q   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      did_q   <= did_d;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Scoreboard bench for i2c_arbiter with a simple
// engine model and per-requester stimulus queues.
module tb_i2c_arbiter;

  localparam int NR = 4;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TO      = 16;
  localparam int ENG_LOW = 10;
`else
  localparam int TO      = 64;
  localparam int ENG_LOW = 20;
`endif

  typedef struct packed {
    logic [1:0] id;
    logic [6:0] a;
    logic [7:0] d;
  } gnt_t;

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic [3:0]    s_valid;
  logic [3:0]    s_ready;
  logic [27:0]   s_addr;
  logic [31:0]   s_data;
  logic          m_start;
  logic [6:0]    m_addr;
  logic [7:0]    m_data;
  logic          m_ready;
  logic          busy;
  logic          done;
  logic [1:0]    done_id;
  logic          err;

  logic eng_rdy;
  logic force_busy = 1'b0;
  logic eng_nodrop = 1'b0;
  assign m_ready = eng_rdy & ~force_busy;

  gnt_t       exp_gnt [$];
  int         exp_done [$];
  logic [6:0] pa [NR][8];
  logic [7:0] pd [NR][8];
  int         pt [NR];
  int         ph [NR];
  logic [3:0] hs_q = '0;
  int         vecs = 0;
  int         errs = 0;

  i2c_arbiter #(
    .NUM_REQ        (NR),
    .ADDR_WIDTH     (7),
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk     (clk),
    .arstn   (arstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_addr  (s_addr),
    .s_data  (s_data),
    .m_start (m_start),
    .m_addr  (m_addr),
    .m_data  (m_data),
    .m_ready (m_ready),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, req, $time);
    end
  endtask

  task automatic push(input int i,
                      input logic [6:0] a,
                      input logic [7:0] d);
    pa[i][pt[i]] = a;
    pd[i][pt[i]] = d;
    pt[i]++;
  endtask

  task automatic expg(input int i,
                      input logic [6:0] a,
                      input logic [7:0] d,
                      input bit with_done);
    gnt_t g;
    g.id = 2'(i);
    g.a  = a;
    g.d  = d;
    exp_gnt.push_back(g);
    if (with_done) exp_done.push_back(i);
  endtask

  task automatic wait_drain(input int lim);
    int k;
    k = 0;
    while ((exp_gnt.size() != 0 || exp_done.size() != 0 ||
            busy || !m_ready) && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (k >= lim) begin
      errs++;
      $display("FAIL drain: timed out after %0d cycles", k);
    end
    repeat (2) @(negedge clk);
  endtask

  // requesters: hold each queued request until accepted
  initial begin
    s_valid = '0;
    s_addr  = '0;
    s_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (hs_q[i]) ph[i]++;
        if (ph[i] < pt[i]) begin
          s_valid[i]        = 1'b1;
          s_addr[i*7 +: 7]  = pa[i][ph[i]];
          s_data[i*8 +: 8]  = pd[i][ph[i]];
        end else begin
          s_valid[i] = 1'b0;
        end
      end
    end
  end

  // engine: drop ready one cycle after start, hold low
  initial begin
    eng_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (m_start && !eng_nodrop) begin
        @(posedge clk);
        #1;
        eng_rdy = 1'b0;
        repeat (ENG_LOW) @(posedge clk);
        #1;
        eng_rdy = 1'b1;
      end
    end
  end

  // monitor: pop and compare on grant, start and done
  initial begin
    logic mr_last;
    logic start_due;
    logic rise_prev;
    gnt_t cur;
    gnt_t e;
    mr_last   = 1'b1;
    start_due = 1'b0;
    rise_prev = 1'b0;
    cur       = '0;
    forever begin
      @(negedge clk);
      if (!arstn) begin
        hs_q      = '0;
        start_due = 1'b0;
        rise_prev = 1'b0;
        mr_last   = m_ready;
      end else begin
        hs_q = s_valid & s_ready;
        if (start_due) begin
          check("start_pulse", 32'(m_start), 1);
          check("m_addr", 32'(m_addr), 32'(cur.a));
          check("m_data", 32'(m_data), 32'(cur.d));
          start_due = 1'b0;
        end else if (m_start) begin
          check("stray_start", 32'(m_start), 0);
        end
        if (s_ready != 0) begin
          if (exp_gnt.size() == 0) begin
            check("stray_grant", 32'(s_ready), 0);
          end else begin
            e = exp_gnt.pop_front();
            check("grant", 32'(s_ready), 32'(1) << e.id);
            check("grant_mready", 32'(m_ready), 1);
            cur       = e;
            start_due = 1'b1;
          end
        end
        if (done) begin
          if (exp_done.size() == 0)
            check("stray_done", 32'(done), 0);
          else
            check("done_id", 32'(done_id),
                  32'(exp_done.pop_front()));
`ifndef I2C_ARB_TIMEOUT_EN
          check("err_tied", 32'(err), 0);
`endif
        end
        if (rise_prev || done)
          check("done_latency", 32'(done), 32'(rise_prev));
        rise_prev = busy && m_ready && !mr_last;
        mr_last   = m_ready;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // reset with all four requesters valid
    expg(0, 7'h01, 8'h10, 1);
    expg(1, 7'h02, 8'h20, 1);
    expg(2, 7'h03, 8'h30, 1);
    expg(3, 7'h04, 8'h40, 1);
    expg(0, 7'h05, 8'h50, 1);
    push(0, 7'h01, 8'h10);
    push(0, 7'h05, 8'h50);
    push(1, 7'h02, 8'h20);
    push(2, 7'h03, 8'h30);
    push(3, 7'h04, 8'h40);
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      check("rst_s_ready", 32'(s_ready), 0);
      check("rst_m_start", 32'(m_start), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
    end
    check("rst_m_addr", 32'(m_addr), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_done_id", 32'(done_id), 0);
    @(posedge clk);
    #1 arstn = 1'b1;
    wait_drain(800);

    // single request from requester 2
    expg(2, 7'h50, 8'hA5, 1);
    push(2, 7'h50, 8'hA5);
    wait_drain(200);

    // pointer at 3, only 1 and 3 valid
    expg(3, 7'h33, 8'hC3, 1);
    expg(1, 7'h11, 8'h3C, 1);
    push(1, 7'h11, 8'h3C);
    push(3, 7'h33, 8'hC3);
    wait_drain(300);

    // engine not ready holds off the grant
    force_busy = 1'b1;
    expg(1, 7'h2A, 8'h96, 1);
    push(1, 7'h2A, 8'h96);
    repeat (6) @(negedge clk);
    check("busy_hold", 32'(s_ready), 0);
    check("busy_idle", 32'(busy), 0);
    @(posedge clk);
    #1 force_busy = 1'b0;
    @(negedge clk);
    check("busy_release", 32'(s_ready), 32'h2);
    wait_drain(200);

    // reset during transfer: no done, pointer back to 0
    expg(0, 7'h0F, 8'hF0, 0);
    push(0, 7'h0F, 8'hF0);
    k = 0;
    while (!(busy && !m_ready) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("reach_wait_done", 32'(busy && !m_ready), 1);
    @(posedge clk);
    #1 arstn = 1'b0;
    @(posedge clk);
    #1 arstn = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    expg(1, 7'h21, 8'h12, 1);
    expg(3, 7'h43, 8'h34, 1);
    push(3, 7'h43, 8'h34);
    push(1, 7'h21, 8'h12);
    repeat (4) @(negedge clk);
    check("engine_hold_after_rst", 32'(s_ready), 0);
    wait_drain(300);

`ifdef I2C_ARB_TIMEOUT_EN
    // engine ignores start: watchdog fires
    eng_nodrop = 1'b1;
    expg(1, 7'h44, 8'h88, 0);
    push(1, 7'h44, 8'h88);
    k = 0;
    while (!m_start && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("to_start", 32'(m_start), 1);
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (err) break;
    end
    check("err_latency", 32'(k), 17);
    check("err_no_done", 32'(done), 0);
    @(negedge clk);
    check("err_pulse_len", 32'(err), 0);
    check("err_idle", 32'(busy), 0);
    eng_nodrop = 1'b0;
    expg(2, 7'h66, 8'h77, 1);
    expg(0, 7'h55, 8'h99, 1);
    push(0, 7'h55, 8'h99);
    push(2, 7'h66, 8'h77);
    wait_drain(300);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
